// File: rtl/imm_pipe_pkg.sv
// Shared definitions for the imm_pipe immediate generator: opcodes,
// format classes and the buffered entry layout.
// Optional feature macro: IMM_PIPE_ZIMM_EN (SYSTEM opcode / zimm decode).
package imm_pipe_pkg;

  // Major opcodes, insn[6:0]
  localparam logic [6:0] R_TYPE   = 7'b0110011;
  localparam logic [6:0] IMM      = 7'b0010011;
  localparam logic [6:0] LOADS    = 7'b0000011;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] STORES   = 7'b0100011;
  localparam logic [6:0] BRANCHES = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;

  // Width of the pc/target fields carried in an entry; the top's AWIDTH
  // must not exceed this.
  localparam int ENTRY_AWIDTH = 32;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6,
    FMT_NONE = 3'd7
  } imm_fmt_e;

  typedef struct packed {
    logic [31:0]             imm;
    logic [ENTRY_AWIDTH-1:0] target;
    logic [ENTRY_AWIDTH-1:0] pc;
    imm_fmt_e                fmt;
    logic                    illegal;
  } imm_entry_t;

  // Value every FIFO slot holds after reset, so the head reads as empty/none.
  localparam imm_entry_t ENTRY_RST = '{
    imm:     32'd0,
    target:  '0,
    pc:      '0,
    fmt:     FMT_NONE,
    illegal: 1'b0
  };

  // Sign-extend a 12-bit field to 32 bits.
  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/imm_pipe_decode.sv
// Purely combinational immediate decoder: (insn, pc) -> one FIFO entry.
// Optional feature macro: IMM_PIPE_ZIMM_EN (recognise SYSTEM, FMT_Z for zimm).
module imm_decode
  import imm_pipe_pkg::*;
(
  input  logic [31:0]             insn,
  input  logic [ENTRY_AWIDTH-1:0] pc,
  output imm_entry_t              entry
);

  logic [31:0] imm;
  imm_fmt_e    fmt;
  logic        illegal;

  // Opcode-keyed immediate extraction; unknown opcodes flag illegal, imm 0.
  always_comb begin
    imm     = 32'd0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (insn[6:0])
      R_TYPE: begin
        fmt = FMT_R;
      end
      IMM, LOADS, JALR: begin
        imm = sext12(insn[31:20]);
        fmt = FMT_I;
      end
      STORES: begin
        imm = sext12({insn[31:25], insn[11:7]});
        fmt = FMT_S;
      end
      BRANCHES: begin
        imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
        fmt = FMT_B;
      end
      JAL: begin
        imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
        fmt = FMT_J;
      end
      LUI, AUIPC: begin
        imm = {insn[31:12], 12'd0};
        fmt = FMT_U;
      end
`ifdef IMM_PIPE_ZIMM_EN
      SYSTEM: begin
        if (insn[14]) begin
          imm = {27'd0, insn[19:15]};
          fmt = FMT_Z;
        end else begin
          imm = sext12(insn[31:20]);
          fmt = FMT_I;
        end
      end
`endif
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // Pack the entry; target is computed for every format, wrapping modulo 2^width.
  always_comb begin
    entry         = ENTRY_RST;
    entry.imm     = imm;
    entry.fmt     = fmt;
    entry.illegal = illegal;
    entry.pc      = pc;
    entry.target  = pc + imm[ENTRY_AWIDTH-1:0];
  end

endmodule

// File: rtl/imm_pipe.sv
// imm_pipe: decode-stage immediate generator with a DEPTH-entry output FIFO.
// Handshake: a transfer happens on a side exactly in a cycle where its valid
// and ready are both 1 at the clock edge; in_ready_o depends only on the
// registered count, never combinationally on out_ready_i. flush_i overrides
// both transfers in its cycle.
// Optional feature macro: IMM_PIPE_ZIMM_EN (handled inside imm_decode).
module imm_pipe
  import imm_pipe_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DWIDTH-1:0] insn_i,
  input  logic [AWIDTH-1:0] pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       imm_o,
  output logic [AWIDTH-1:0] target_o,
  output logic [2:0]        fmt_o,
  output logic              illegal_o,
  output logic [AWIDTH-1:0] pc_o,
  output logic [15:0]       illegal_cnt_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   illegal_cnt;
  imm_entry_t    fifo_q [DEPTH];
  imm_entry_t    dec;
  imm_entry_t    head;
  logic          push, pop;

  imm_decode u_decode (
    .insn  (insn_i[31:0]),
    .pc    (ENTRY_AWIDTH'(pc_i)),
    .entry (dec)
  );

  assign in_ready_o  = (count < CW'(DEPTH));
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i && !flush_i;

  // Outputs come straight from the head slot registers.
  assign head          = fifo_q[rd_ptr];
  assign imm_o         = head.imm;
  assign target_o      = head.target[AWIDTH-1:0];
  assign pc_o          = head.pc[AWIDTH-1:0];
  assign fmt_o         = head.fmt;
  assign illegal_o     = head.illegal;
  assign illegal_cnt_o = illegal_cnt;

  // Pointers and occupancy; flush empties the FIFO ahead of any push/pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; slots are cleared only by reset, flush just drops pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= ENTRY_RST;
    end else if (push) begin
      fifo_q[wr_ptr] <= dec;
    end
  end

  // Saturating count of accepted illegal entries; survives flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_cnt <= 16'd0;
    end else if (push && dec.illegal && (illegal_cnt != 16'hFFFF)) begin
      illegal_cnt <= illegal_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_imm_pipe.sv
// Self-checking bench for imm_pipe: directed steps in one initial block, a
// negedge monitor with an expected-entry queue and an illegal-count model.
module tb_imm_pipe;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] insn;
  logic [31:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] imm;
  logic [31:0] target;
  logic [2:0]  fmt;
  logic        illegal;
  logic [31:0] pc_out;
  logic [15:0] illegal_cnt;

  int errors = 0;
  int checks = 0;

  logic [99:0] exp_q[$];
  logic [15:0] exp_cnt = 16'd0;

  imm_pipe dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .insn_i       (insn),
    .pc_i         (pc),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .imm_o        (imm),
    .target_o     (target),
    .fmt_o        (fmt),
    .illegal_o    (illegal),
    .pc_o         (pc_out),
    .illegal_cnt_o(illegal_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode: {imm, target, pc, fmt, illegal}
  function automatic logic [99:0] model(input logic [31:0] i, input logic [31:0] p);
    logic [31:0] m;
    logic [2:0]  f;
    logic        il;
    m = 32'd0; f = 3'd7; il = 1'b0;
    case (i[6:0])
      7'h33: f = 3'd0;
      7'h13, 7'h03, 7'h67: begin m = {{20{i[31]}}, i[31:20]}; f = 3'd1; end
      7'h23: begin m = {{20{i[31]}}, i[31:25], i[11:7]}; f = 3'd2; end
      7'h63: begin m = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; f = 3'd3; end
      7'h6F: begin m = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; f = 3'd5; end
      7'h37, 7'h17: begin m = {i[31:12], 12'd0}; f = 3'd4; end
`ifdef IMM_PIPE_ZIMM_EN
      7'h73: begin
        if (i[14]) begin m = {27'd0, i[19:15]}; f = 3'd6; end
        else begin m = {{20{i[31]}}, i[31:20]}; f = 3'd1; end
      end
`endif
      default: il = 1'b1;
    endcase
    return {m, p + m, p, f, il};
  endfunction

  function automatic logic [99:0] head();
    return {imm, target, pc_out, fmt, illegal};
  endfunction

  task automatic chk(input string tag, input logic [99:0] obs, input logic [99:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p);
    in_valid = 1'b1;
    insn     = i;
    pc       = p;
  endtask

  // scoreboard: push at accept, pop/compare at output handshake
  always @(negedge clk) begin
    logic [99:0] e;
    if (!reset_n) begin
      exp_q.delete();
      exp_cnt = 16'd0;
    end else begin
      chk("illegal_cnt", {84'd0, illegal_cnt}, {84'd0, exp_cnt});
      chk("out_valid", {99'd0, out_valid}, {99'd0, exp_q.size() != 0});
      chk("in_ready", {99'd0, in_ready}, {99'd0, exp_q.size() < 2});
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pop", 100'd1, 100'd0);
          end else begin
            e = exp_q.pop_front();
            chk("sb_entry", head(), e);
          end
        end
        if (in_valid && in_ready) begin
          e = model(insn, pc);
          exp_q.push_back(e);
          if (e[0] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
      end
    end
  end

  initial begin
    logic [31:0] r;
    logic [6:0]  ops [11];
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h73, 7'h7F};

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; insn = 32'd0; pc = 32'd0; out_ready = 1'b0;
    repeat (2) cyc();
    chk("rst_head", head(), {96'd0, 3'd7, 1'b0});
    chk("rst_valid", {99'd0, out_valid}, 100'd0);
    chk("rst_cnt", {84'd0, illegal_cnt}, 100'd0);
    reset_n = 1'b1;
    cyc();

    // addi x1,x0,-1
    out_ready = 1'b1;
    drive(32'hFFF00093, 32'h0);
    cyc();
    in_valid = 1'b0;
    chk("addi_valid", {99'd0, out_valid}, 100'd1);
    chk("addi", head(), {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 3'd1, 1'b0});
    cyc();

    // beq x0,x0,-4
    drive(32'hFE000EE3, 32'h100);
    cyc();
    in_valid = 1'b0;
    chk("beq", head(), {32'hFFFFFFFC, 32'h000000FC, 32'h100, 3'd3, 1'b0});
    cyc();

    // lui then jal back-to-back
    drive(32'h123452B7, 32'h200);
    cyc();
    drive(32'h001000EF, 32'h204);
    chk("lui", head(), {32'h12345000, 32'h12345200, 32'h200, 3'd4, 1'b0});
    cyc();
    in_valid = 1'b0;
    chk("jal", head(), {32'h00000800, 32'h00000A04, 32'h204, 3'd5, 1'b0});
    cyc();

    // backpressure: third entry held until a slot frees
    out_ready = 1'b0;
    drive(32'h00100013, 32'h300); cyc();
    drive(32'h00200013, 32'h304); cyc();
    drive(32'h00300013, 32'h308);
    chk("bp_full", {99'd0, in_ready}, 100'd0);
    cyc();
    chk("bp_held", {99'd0, in_ready}, 100'd0);
    chk("bp_head1", head(), model(32'h00100013, 32'h300));
    out_ready = 1'b1;
    cyc();
    chk("bp_head2", head(), model(32'h00200013, 32'h304));
    chk("bp_ready", {99'd0, in_ready}, 100'd1);
    cyc();
    in_valid = 1'b0;
    chk("bp_head3", head(), model(32'h00300013, 32'h308));
    cyc();
    chk("bp_drained", {99'd0, out_valid}, 100'd0);

    // csrrwi x0,0x300,5
    drive(32'h3002D073, 32'h400);
    cyc();
    in_valid = 1'b0;
`ifdef IMM_PIPE_ZIMM_EN
    chk("csrrwi", head(), {32'd5, 32'h405, 32'h400, 3'd6, 1'b0});
    cyc();
    chk("csrrwi_cnt", {84'd0, illegal_cnt}, 100'd0);
`else
    chk("csrrwi", head(), {32'd0, 32'h400, 32'h400, 3'd7, 1'b1});
    cyc();
    chk("csrrwi_cnt", {84'd0, illegal_cnt}, 100'd1);
`endif

    // flush with two buffered entries (one illegal) plus an offered illegal
    out_ready = 1'b0;
    drive(32'h00000000, 32'h500); cyc();
    drive(32'h00500093, 32'h504); cyc();
    r = {16'd0, illegal_cnt};
    flush = 1'b1;
    drive(32'h0000007F, 32'h508);
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", {99'd0, out_valid}, 100'd0);
    chk("flush_ready", {99'd0, in_ready}, 100'd1);
    chk("flush_cnt", {84'd0, illegal_cnt}, {68'd0, r});
    cyc();

    // reset asserted mid-stream clears outputs at once
    drive(32'h00000000, 32'h600); cyc();
    drive(32'hABCDE037, 32'h604); cyc();
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("amid_rst_head", head(), {96'd0, 3'd7, 1'b0});
    chk("amid_rst_valid", {99'd0, out_valid}, 100'd0);
    chk("amid_rst_cnt", {84'd0, illegal_cnt}, 100'd0);
    cyc();
    reset_n = 1'b1;
    cyc();

    // random traffic, checked by the scoreboard
    for (int k = 0; k < 300; k++) begin
      r = $urandom();
      insn = {r[31:7], ops[$urandom_range(0, 10)]};
      pc = $urandom() & 32'hFFFFFFFC;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cyc();
    chk("drain", {68'd0, 32'(exp_q.size())}, 100'd0);

    // saturate the illegal counter
    drive(32'h00000000, 32'h700);
    repeat (65540) cyc();
    in_valid = 1'b0;
    cyc();
    chk("cnt_sat", {84'd0, illegal_cnt}, {84'd0, 16'hFFFF});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
